// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family: FSM encoding,
// requester count and the grant-id width.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: returns the first set request bit
// found when scanning upward from ptr with wrap-around.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  win_id
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the closest hit to ptr wins last.
    always_comb begin
        any    = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + k[ID_W-1:0];
            if (req[idx]) begin
                any    = 1'b1;
                win_id = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a bounded hold time; the grant is
// registered and a dead cycle always separates consecutive grants.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             timeout
);

    if (N != N_REQ) begin : g_n_check
        $error("rr_arbiter4 supports exactly 4 requesters");
    end

    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : CNT_TOP;

    arb_state_e       state, state_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [ID_W-1:0]  id_nxt;
    logic             timeout_nxt;
    logic             pick_any;
    logic [ID_W-1:0]  pick_id;
    logic             hold_expired;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .win_id (pick_id)
    );

    // With HOLD_MAX=0 the counter only saturates and never forces a release.
    assign hold_expired = (HOLD_MAX != 0) && (hold_cnt == CNT_LAST);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = hold_cnt;
        gnt_nxt     = gnt;
        id_nxt      = gnt_id;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    gnt_nxt   = onehot(pick_id);
                    id_nxt    = pick_id;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id] || hold_expired) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    id_nxt      = '0;
                    ptr_nxt     = gnt_id + ID_W'(1);
                    timeout_nxt = req[gnt_id];
                end else if (hold_cnt != CNT_TOP) begin
                    cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= cnt_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= id_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two instances (HOLD_MAX=8 and unlimited) compared
// cycle by cycle against a behavioural round-robin model.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt_a, gnt_b;
    logic       gnt_valid_a, gnt_valid_b;
    logic [1:0] gnt_id_a, gnt_id_b;
    logic       timeout_a, timeout_b;

    int assert_count = 0;
    int fail_count   = 0;

    int hold_max [2] = '{8, 0};
    int m_owner  [2];
    int m_ptr    [2];
    int m_held   [2];
    bit m_to     [2];
    bit prev_to  [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    rr_arbiter4 #(.N(4), .HOLD_MAX(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt_a),
        .gnt_valid (gnt_valid_a),
        .gnt_id    (gnt_id_a),
        .timeout   (timeout_a)
    );

    rr_arbiter4 #(.N(4), .HOLD_MAX(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt_b),
        .gnt_valid (gnt_valid_b),
        .gnt_id    (gnt_id_b),
        .timeout   (timeout_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: owner=-1 means idle; held counts cycles the grant has been visible.
    task automatic modelStep(input int k, input bit r, input logic [3:0] rq);
        if (r) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_held[k]  = 0;
            m_to[k]    = 1'b0;
        end else if (m_owner[k] < 0) begin
            m_to[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_owner[k] < 0 && rq[(m_ptr[k] + i) % 4]) begin
                    m_owner[k] = (m_ptr[k] + i) % 4;
                    m_held[k]  = 1;
                end
            end
        end else if (!rq[m_owner[k]]) begin
            m_ptr[k]   = (m_owner[k] + 1) % 4;
            m_owner[k] = -1;
            m_to[k]    = 1'b0;
        end else if (hold_max[k] != 0 && m_held[k] == hold_max[k]) begin
            m_ptr[k]   = (m_owner[k] + 1) % 4;
            m_owner[k] = -1;
            m_to[k]    = 1'b1;
        end else begin
            m_held[k]++;
            m_to[k] = 1'b0;
        end
    endtask

    task automatic checkInstance(input int k, input logic [3:0] g, input logic v,
                                 input logic [1:0] id, input logic to);
        logic [3:0] exp_g;
        string      sfx;
        sfx   = (k == 0) ? "_a" : "_b";
        exp_g = (m_owner[k] < 0) ? 4'b0000 : 4'(1 << m_owner[k]);
        checkOutput({"gnt", sfx}, 32'(g), 32'(exp_g));
        checkOutput({"gnt_valid", sfx}, 32'(v), (m_owner[k] < 0) ? 32'd0 : 32'd1);
        checkOutput({"gnt_id", sfx}, 32'(id), (m_owner[k] < 0) ? 32'd0 : 32'(m_owner[k]));
        checkOutput({"timeout", sfx}, 32'(to), 32'(m_to[k]));
        checkOutput({"timeout_twice", sfx}, 32'(to & prev_to[k]), 32'd0);
        prev_to[k] = to;
    endtask

    task automatic applyStimulus(input bit r, input logic [3:0] rq);
        @(negedge clk);
        rst = r;
        req = rq;
        @(posedge clk);
        modelStep(0, r, rq);
        modelStep(1, r, rq);
        #1;
        checkInstance(0, gnt_a, gnt_valid_a, gnt_id_a, timeout_a);
        checkInstance(1, gnt_b, gnt_valid_b, gnt_id_b, timeout_b);
    endtask

    initial begin
        int         order [$];
        int         exp_order [5] = '{0, 1, 2, 3, 0};
        logic       prev_valid;
        logic [3:0] rq;
        int         run_len;
        bit         to_seen;

        $display("[TB] reset with all requests high");
        applyStimulus(1'b1, 4'b1111);
        applyStimulus(1'b1, 4'b1111);
        checkOutput("rst_gnt", 32'(gnt_a), 32'h0);
        checkOutput("rst_valid", 32'(gnt_valid_a), 32'h0);
        checkOutput("rst_id", 32'(gnt_id_a), 32'h0);
        checkOutput("rst_timeout", 32'(timeout_a), 32'h0);
        applyStimulus(1'b0, 4'b1111);
        checkOutput("first_gnt", 32'(gnt_a), 32'h1);

        $display("[TB] rotation, owners drop after two cycles");
        applyStimulus(1'b1, 4'b0000);
        prev_valid = 1'b0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            rq = 4'b1111;
            if (m_owner[1] >= 0 && m_held[1] >= 2) rq[m_owner[1]] = 1'b0;
            applyStimulus(1'b0, rq);
            if (gnt_valid_b && !prev_valid) order.push_back(int'(gnt_id_b));
            prev_valid = gnt_valid_b;
        end
        checkOutput("rot_len", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            checkOutput("rot_order", 32'(order[i]), 32'(exp_order[i]));

        $display("[TB] hold timeout on requester 2");
        applyStimulus(1'b1, 4'b0000);
        run_len = 0;
        to_seen = 1'b0;
        for (int c = 0; c < 30 && !to_seen; c++) begin
            applyStimulus(1'b0, 4'b0100);
            if (gnt_a == 4'b0100) run_len++;
            if (timeout_a) to_seen = 1'b1;
        end
        checkOutput("to_seen", 32'(to_seen), 32'd1);
        checkOutput("to_len", 32'(run_len), 32'd8);
        checkOutput("to_idle", 32'(gnt_a), 32'h0);
        applyStimulus(1'b0, 4'b0100);
        checkOutput("to_regrant", 32'(gnt_a), 32'h4);
        checkOutput("nolimit_hold", 32'(gnt_b), 32'h4);

        $display("[TB] pointer wrap");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0100);
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0011);
        checkOutput("wrap_id", 32'(gnt_id_a), 32'd0);
        checkOutput("wrap_gnt", 32'(gnt_a), 32'h1);
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0011);
        checkOutput("wrap_next", 32'(gnt_a), 32'h2);

        $display("[TB] no preemption");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0010);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b1010);
            checkOutput("nopre_hold", 32'(gnt_a), 32'h2);
        end
        applyStimulus(1'b0, 4'b1000);
        checkOutput("nopre_dead", 32'(gnt_a), 32'h0);
        applyStimulus(1'b0, 4'b1000);
        checkOutput("nopre_next", 32'(gnt_a), 32'h8);

        $display("[TB] reset mid-grant");
        applyStimulus(1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0100);
        applyStimulus(1'b1, 4'b0100);
        checkOutput("midrst_gnt", 32'(gnt_a), 32'h0);
        applyStimulus(1'b0, 4'b0101);
        checkOutput("midrst_win", 32'(gnt_a), 32'h1);

        $display("[TB] randomized traffic");
        rq = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            applyStimulus($urandom_range(0, 99) == 0, rq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
